mem_arbiter_ctrl: RTL and testbench

MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

---
 rtl/mem_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mem_arbiter_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and the processor control block:
// FSM state encoding, default widths and a small index-width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int DEF_NPORT     = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_WAIT_CYC  = 1;

  // Width of the RAM strobe cycle counter (WAIT_CYC is 1..15).
  localparam int WAIT_CNT_W = 4;

  // Bits needed to hold a port index; at least one bit for a single port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic: searches from last_grant+1 (mod NPORT) upward and
// grants the first requesting port. Produces nothing while en is low.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NPORT = DEF_NPORT,
  localparam int IDX_W = idx_w(NPORT)
) (
  input  logic             en,
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NPORT-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the ports in rotated priority order and keep the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    if (en) begin
      for (int off = 1; off <= NPORT; off++) begin
        sum = {1'b0, last_grant} + (IDX_W+1)'(off);
        if (sum >= (IDX_W+1)'(NPORT)) begin
          sum = sum - (IDX_W+1)'(NPORT);
        end
        cand = sum[IDX_W-1:0];
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Multi-port memory arbiter: grants one requester at a time (round-robin),
// runs a fixed-length RAM strobe, then returns a one-cycle ready pulse.
// Out-of-range addresses skip the RAM and complete with err. All outputs
// come straight from flops.
module mem_arbiter_ctrl
  import mem_pkg::*;
#(
  parameter int NPORT     = DEF_NPORT,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        Valid,
  input  logic [NPORT-1:0]        RW,
  input  logic [NPORT*ADDR_W-1:0] Addr_CPU,
  input  logic [NPORT*DATA_W-1:0] Data_wr,
  output logic [NPORT-1:0]        ready,
  output logic                    err,
  output logic [DATA_W-1:0]       Data_rd,
  output logic                    busy,
  output logic [ADDR_W-1:0]       Addr_RAM,
  output logic [DATA_W-1:0]       Data_RAM_wr,
  input  logic [DATA_W-1:0]       Data_RAM_rd,
  output logic                    rdEn,
  output logic                    wrEn
);

  localparam int IDX_W = idx_w(NPORT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYC - 1);

  // Handshake: a port raises Valid with RW/Addr_CPU/Data_wr stable and keeps
  // them until accepted (the IDLE edge that grants it); after that the inputs
  // are don't-care. Completion is a single-cycle ready[port] pulse, qualified
  // by err. Dropping Valid before the edge following ready ends the request;
  // keeping it high issues a new one.

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    rw_q, rw_d;
  logic                    err_lat_q, err_lat_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NPORT-1:0]        ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       data_rd_q, data_rd_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       addr_ram_q, addr_ram_d;
  logic [DATA_W-1:0]       data_ram_wr_q, data_ram_wr_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;

  logic                    arb_en;
  logic [NPORT-1:0]        gnt_oh;
  logic [IDX_W-1:0]        gnt_idx;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic                    req_rw;
  logic                    req_in_range;

  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter #(.NPORT(NPORT)) u_rr_arbiter (
    .en         (arb_en),
    .req        (Valid),
    .last_grant (last_grant_q),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx)
  );

  // Pick the granted port's request fields out of the packed buses.
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_rw    = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt_oh[i]) begin
        req_addr  = Addr_CPU[i*ADDR_W +: ADDR_W];
        req_wdata = Data_wr[i*DATA_W +: DATA_W];
        req_rw    = RW[i];
      end
    end
  end

  assign req_in_range = (64'(req_addr) < 64'(MEM_DEPTH));

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    rw_d          = rw_q;
    err_lat_d     = err_lat_q;
    wait_cnt_d    = wait_cnt_q;
    ready_d       = '0;
    err_d         = 1'b0;
    data_rd_d     = data_rd_q;
    addr_ram_d    = addr_ram_q;
    data_ram_wr_d = data_ram_wr_q;
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_oh) begin
          last_grant_d = gnt_idx;
          grant_d      = gnt_idx;
          rw_d         = req_rw;
          wait_cnt_d   = '0;
          if (req_in_range) begin
            err_lat_d     = 1'b0;
            state_d       = ST_ACCESS;
            addr_ram_d    = req_addr;
            data_ram_wr_d = req_wdata;
            rd_en_d       = req_rw;
            wr_en_d       = !req_rw;
          end else begin
            // Bad address: RAM is never touched and its bus keeps old values.
            err_lat_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_RESP;
          if (rw_q) begin
            data_rd_d = Data_RAM_rd;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          rd_en_d    = rw_q;
          wr_en_d    = !rw_q;
        end
      end
      ST_RESP: begin
        ready_d[grant_q] = 1'b1;
        err_d            = err_lat_q;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Single register bank for FSM state and every output; reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= IDX_W'(NPORT - 1);
      grant_q       <= '0;
      rw_q          <= 1'b0;
      err_lat_q     <= 1'b0;
      wait_cnt_q    <= '0;
      ready_q       <= '0;
      err_q         <= 1'b0;
      data_rd_q     <= '0;
      busy_q        <= 1'b0;
      addr_ram_q    <= '0;
      data_ram_wr_q <= '0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      rw_q          <= rw_d;
      err_lat_q     <= err_lat_d;
      wait_cnt_q    <= wait_cnt_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      data_rd_q     <= data_rd_d;
      busy_q        <= busy_d;
      addr_ram_q    <= addr_ram_d;
      data_ram_wr_q <= data_ram_wr_d;
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
    end
  end

  assign ready       = ready_q;
  assign err         = err_q;
  assign Data_rd     = data_rd_q;
  assign busy        = busy_q;
  assign Addr_RAM    = addr_ram_q;
  assign Data_RAM_wr = data_ram_wr_q;
  assign rdEn        = rd_en_q;
  assign wrEn        = wr_en_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl. Three instances with WAIT_CYC = 1, 3
// and 4, each with its own stimulus and a tiny RAM model.
module tb_mem_arbiter_ctrl;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 3, 4};

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n       [NI];
  logic [1:0]  valid       [NI];
  logic [1:0]  rw          [NI];
  logic [63:0] addr_cpu    [NI];
  logic [63:0] data_wr     [NI];
  logic [1:0]  ready       [NI];
  logic        err         [NI];
  logic [31:0] data_rd     [NI];
  logic        busy        [NI];
  logic [31:0] addr_ram    [NI];
  logic [31:0] data_ram_wr [NI];
  logic [31:0] data_ram_rd [NI];
  logic        rd_en       [NI];
  logic        wr_en       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter_ctrl #(
      .NPORT(2), .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_CYC(WC[g])
    ) u_dut (
      .clk         (clk),
      .reset       (rst_n[g]),
      .Valid       (valid[g]),
      .RW          (rw[g]),
      .Addr_CPU    (addr_cpu[g]),
      .Data_wr     (data_wr[g]),
      .ready       (ready[g]),
      .err         (err[g]),
      .Data_rd     (data_rd[g]),
      .busy        (busy[g]),
      .Addr_RAM    (addr_ram[g]),
      .Data_RAM_wr (data_ram_wr[g]),
      .Data_RAM_rd (data_ram_rd[g]),
      .rdEn        (rd_en[g]),
      .wrEn        (wr_en[g])
    );
  end

  // ---------------- RAM model (16 words per instance) ----------------
  logic [31:0] ram [NI][16];

  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      if (wr_en[d]) ram[d][addr_ram[d][3:0]] <= data_ram_wr[d];
    end
  end

  always_comb begin
    for (int d = 0; d < NI; d++) data_ram_rd[d] = ram[d][addr_ram[d][3:0]];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int viol  = 0;
  logic [1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants sampled every cycle; tallied and checked at the end.
  always @(negedge clk) begin
    for (int d = 0; d < NI; d++) begin
      if (rd_en[d] && wr_en[d]) viol++;
      if (err[d] && (ready[d] == 2'b00)) viol++;
      if ((rd_en[d] || wr_en[d]) && !busy[d]) viol++;
      if (ready[d] == 2'b11) viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int d, input int p, input logic v, input logic r,
                         input logic [31:0] a, input logic [31:0] wd);
    valid[d][p]             = v;
    rw[d][p]                = r;
    addr_cpu[d][p*32 +: 32] = a;
    data_wr[d][p*32 +: 32]  = wd;
  endtask

  // Issue one request on an idle instance (call at a negedge). Inputs are
  // scrambled right after acceptance; lat counts edges from acceptance to
  // the edge that raises ready.
  task automatic run_xact(input int d, input int p, input logic r,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int rd_cnt, output int wr_cnt,
                          output logic [1:0] rdy, output logic e);
    set_req(d, p, 1'b1, r, a, wd);
    @(negedge clk);
    set_req(d, p, 1'b0, ~r, ~a, ~wd);
    lat = 0; rd_cnt = 0; wr_cnt = 0;
    while (ready[d] == 2'b00 && lat < 40) begin
      if (rd_en[d]) rd_cnt++;
      if (wr_en[d]) wr_cnt++;
      @(negedge clk);
      lat++;
    end
    rdy = ready[d];
    e   = err[d];
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int         lat, rc, wc, guard, seen;
  logic [1:0] rdy, obs;
  logic       e;

  initial begin
    for (int d = 0; d < NI; d++) begin
      rst_n[d] = 1'b0; valid[d] = '0; rw[d] = '0; addr_cpu[d] = '0; data_wr[d] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset values on every instance.
    for (int d = 0; d < NI; d++) begin
      chk("rst_ready", 64'(ready[d]), 0);
      chk("rst_err", 64'(err[d]), 0);
      chk("rst_busy", 64'(busy[d]), 0);
      chk("rst_strobes", 64'({rd_en[d], wr_en[d]}), 0);
      chk("rst_data_rd", 64'(data_rd[d]), 0);
      chk("rst_addr_ram", 64'(addr_ram[d]), 0);
      chk("rst_data_ram_wr", 64'(data_ram_wr[d]), 0);
    end
    for (int d = 0; d < NI; d++) rst_n[d] = 1'b1;
    @(negedge clk);

    // ---- WAIT_CYC=1: store DEADBEEF at 5 via port1, read it via port0 ----
    run_xact(0, 1, 1'b0, 32'd5, 32'hDEADBEEF, lat, rc, wc, rdy, e);
    chk("a_wr_lat", 64'(lat), 2);
    chk("a_wr_strobe", 64'(wc), 1);
    chk("a_wr_ready", 64'(rdy), 64'h2);
    chk("a_wr_data_rd_kept", 64'(data_rd[0]), 0);

    run_xact(0, 0, 1'b1, 32'd5, 32'h0, lat, rc, wc, rdy, e);
    chk("a_rd_lat", 64'(lat), 2);
    chk("a_rd_strobe", 64'({rc[7:0], wc[7:0]}), 64'h0100);
    chk("a_rd_ready", 64'(rdy), 64'h1);
    chk("a_rd_err", 64'(e), 0);
    chk("a_rd_data", 64'(data_rd[0]), 64'hDEADBEEF);

    // Out-of-range read from port1: no strobe, ready+err one edge later.
    run_xact(0, 1, 1'b1, 32'd300, 32'h0, lat, rc, wc, rdy, e);
    chk("a_oor_lat", 64'(lat), 1);
    chk("a_oor_strobe", 64'(rc + wc), 0);
    chk("a_oor_ready", 64'(rdy), 64'h2);
    chk("a_oor_err", 64'(e), 1);
    chk("a_oor_data_rd_kept", 64'(data_rd[0]), 64'hDEADBEEF);
    chk("a_oor_addr_ram_kept", 64'(addr_ram[0]), 5);
    chk("a_err_cleared", 64'(err[0]), 0);

    // Contention: both ports hold Valid; grants must alternate from port0.
    set_req(0, 0, 1'b1, 1'b1, 32'd1, 32'h0);
    set_req(0, 1, 1'b1, 1'b1, 32'd2, 32'h0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (ready[0] == 2'b00 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      obs = ready[0][1] ? 2'd1 : (ready[0][0] ? 2'd0 : 2'd3);
      chk("a_rr_grant", 64'(obs), 64'(exp_q.pop_front()));
      chk("a_rr_wait", 64'(guard <= 3), 1);
      if (k < 3) @(negedge clk);
    end
    valid[0] = 2'b00;
    repeat (2) @(negedge clk);
    chk("a_dropped_not_regranted", 64'(busy[0]), 0);

    // ---- WAIT_CYC=3: write 0x12345678 to 10 via port1, read back ----
    run_xact(1, 1, 1'b0, 32'd10, 32'h12345678, lat, rc, wc, rdy, e);
    chk("b_wr_lat", 64'(lat), 4);
    chk("b_wr_strobe", 64'({rc[7:0], wc[7:0]}), 64'h0003);
    chk("b_wr_ready", 64'(rdy), 64'h2);
    chk("b_addr_ram_hold", 64'(addr_ram[1]), 10);
    chk("b_data_ram_wr_hold", 64'(data_ram_wr[1]), 64'h12345678);

    run_xact(1, 0, 1'b1, 32'd10, 32'h0, lat, rc, wc, rdy, e);
    chk("b_rd_lat", 64'(lat), 4);
    chk("b_rd_strobe", 64'({rc[7:0], wc[7:0]}), 64'h0300);
    chk("b_rd_ready", 64'(rdy), 64'h1);
    chk("b_rd_data", 64'(data_rd[1]), 64'h12345678);

    // ---- WAIT_CYC=4: reset during the second ACCESS cycle ----
    set_req(2, 1, 1'b1, 1'b1, 32'd3, 32'h0);
    @(negedge clk);
    chk("c_access_rd_en", 64'(rd_en[2]), 1);
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("c_abort_rd_en", 64'(rd_en[2]), 0);
    chk("c_abort_busy", 64'(busy[2]), 0);
    chk("c_abort_ready", 64'(ready[2]), 0);
    rst_n[2] = 1'b1;
    valid[2] = 2'b00;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[2] != 2'b00) seen++;
    end
    chk("c_no_ready_after_abort", 64'(seen), 0);

    // Both ports request after reset: port0 must be first.
    set_req(2, 0, 1'b1, 1'b1, 32'd4, 32'h0);
    set_req(2, 1, 1'b1, 1'b1, 32'd3, 32'h0);
    @(negedge clk);
    lat = 0;
    while (ready[2] == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("c_post_rst_ready", 64'(ready[2]), 64'h1);
    chk("c_post_rst_err", 64'(err[2]), 0);
    chk("c_post_rst_lat", 64'(lat), 5);
    valid[2] = 2'b00;
    repeat (8) @(negedge clk);

    chk("protocol_invariants", 64'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
